// File: rtl/mod_add_sub_if.sv
// Handshake bundle for mod_add_sub.
// Input side:  in_valid/in_ready qualify A, B, Sub (Sub=1 selects A-B).
// Output side: out_valid/out_ready qualify Sum, Wrap.
// The master modport belongs to the producer/consumer environment.
// The slave modport belongs to the arithmetic stage.
interface mod_add_sub_if #(
  parameter int unsigned WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Wrap;

  modport master (
    output in_valid, A, B, Sub, out_ready,
    input  in_ready, out_valid, Sum, Wrap
  );

  modport slave (
    input  in_valid, A, B, Sub, out_ready,
    output in_ready, out_valid, Sum, Wrap
  );
endinterface

// File: rtl/mod_add_sub.sv
// Two-stage pipelined modular adder/subtractor: (A + B) mod Q or (A - B) mod Q.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, flushes both stages
//   bus  - mod_add_sub_if.slave. It carries:
//          in_valid/in_ready/A/B/Sub on the input side.
//          out_valid/out_ready/Sum/Wrap on the output side.
// Operands must be < Q for Sum to land in [0, Q-1].
// Wrap flags that the single modular correction was applied.
// Q must satisfy 2 <= Q <= 2^WIDTH - 1.
module mod_add_sub #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned Q     = 3329
) (
  input  logic          clk,
  input  logic          rst,
  mod_add_sub_if.slave  bus
);

  localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

  // Stage 1: raw sum/difference on WIDTH+1 bits.
  // For a difference, the MSB is the borrow.
  logic             v1;
  logic             sub1;
  logic [WIDTH:0]   raw1;

  // Stage 2: registered outputs.
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             wrap_r;

  logic             adv;
  logic [WIDTH:0]   raw_n;
  logic [WIDTH:0]   corr;
  logic [WIDTH-1:0] sum_n;
  logic             wrap_n;

  // One global advance.
  // A bubble still occupies its slot, so the pipe moves whenever the output
  // register is empty or being consumed.
  assign adv           = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_r;
  assign bus.Sum       = sum_r;
  assign bus.Wrap      = wrap_r;

  always_comb begin
    if (bus.Sub) raw_n = {1'b0, bus.A} - {1'b0, bus.B};
    else         raw_n = {1'b0, bus.A} + {1'b0, bus.B};
  end

  always_comb begin
    if (sub1) begin
      wrap_n = raw1[WIDTH];
      corr   = raw1 + QX;
    end else begin
      wrap_n = (raw1 >= QX);
      corr   = raw1 - QX;
    end
    sum_n = wrap_n ? corr[WIDTH-1:0] : raw1[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      sub1        <= 1'b0;
      raw1        <= '0;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      wrap_r      <= 1'b0;
    end else if (adv) begin
      v1          <= bus.in_valid;
      sub1        <= bus.Sub;
      raw1        <= raw_n;
      out_valid_r <= v1;
      // Data holds across a bubble; only out_valid drops.
      if (v1) begin
        sum_r  <= sum_n;
        wrap_r <= wrap_n;
      end
    end
  end

endmodule

// File: tb/tb_mod_add_sub.sv
// Scoreboard bench for mod_add_sub with three instances:
// the default 12-bit/3329 instance, an 8-bit/251 instance and a 23-bit/8380417 instance.
module tb_mod_add_sub;

  typedef struct {
    logic [31:0] sum;
    logic        wrap;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   ncmp;
  int   nfail;
  int   nout12;
  int   nout8;
  int   nout23;
  bit   lat_chk;
  bit   bp_en;

  exp_t q12[$];
  exp_t q8[$];
  exp_t q23[$];

  mod_add_sub_if #(.WIDTH(12)) b12 ();
  mod_add_sub_if #(.WIDTH(8))  b8  ();
  mod_add_sub_if #(.WIDTH(23)) b23 ();

  mod_add_sub #(.WIDTH(12), .Q(3329)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .bus (b12.slave)
  );

  mod_add_sub #(.WIDTH(8), .Q(251)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  mod_add_sub #(.WIDTH(23), .Q(8380417)) u_dut23 (
    .clk (clk),
    .rst (rst),
    .bus (b23.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: true modular result plus the textbook wrap condition.
  function automatic exp_t model(input longint a, input longint b, input bit sub,
                                 input longint q);
    exp_t   e;
    longint r;
    r      = sub ? a - b : a + b;
    e.sum  = 32'(((r % q) + q) % q);
    e.wrap = sub ? (a < b) : (a + b >= q);
    e.acc  = 0;
    return e;
  endfunction

  // Drive one transaction on the 12-bit instance.
  // The expected response is queued when it is accepted.
  task automatic send12(input int a, input int b, input bit sub,
                        input int esum, input bit ewrap, input bit push);
    bit   acc;
    int   n;
    exp_t e;
    b12.A        = a[11:0];
    b12.B        = b[11:0];
    b12.Sub      = sub;
    b12.in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = b12.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send12_timeout", 64'd0, 64'd1);
    else if (push) begin
      e.sum  = 32'(esum);
      e.wrap = ewrap;
      e.acc  = cyc;
      q12.push_back(e);
    end
    b12.in_valid = 1'b0;
  endtask

  task automatic send8(input int a, input int b, input bit sub);
    bit   acc;
    exp_t e;
    b8.A        = a[7:0];
    b8.B        = b[7:0];
    b8.Sub      = sub;
    b8.in_valid = 1'b1;
    @(negedge clk);
    acc = b8.in_ready;
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    check("in_ready8", 64'(acc), 64'd1);
    if (acc) begin
      e = model(a, b, sub, 251);
      q8.push_back(e);
    end
  endtask

  task automatic send23(input int a, input int b, input bit sub);
    bit   acc;
    exp_t e;
    b23.A        = a[22:0];
    b23.B        = b[22:0];
    b23.Sub      = sub;
    b23.in_valid = 1'b1;
    @(negedge clk);
    acc = b23.in_ready;
    @(posedge clk);
    #1;
    b23.in_valid = 1'b0;
    check("in_ready23", 64'(acc), 64'd1);
    if (acc) begin
      e = model(a, b, sub, 8380417);
      q23.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q12.size() + q8.size() + q23.size()) != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_q12", 64'(q12.size()), 64'd0);
    check("drain_q8",  64'(q8.size()),  64'd0);
    check("drain_q23", 64'(q23.size()), 64'd0);
  endtask

  // Random backpressure on the 12-bit instance.
  always @(posedge clk) begin
    #1;
    if (bp_en) b12.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor for the 12-bit instance:
  // checks the handshake, stall stability and in-order results.
  bit               stalled;
  logic [11:0]      prev_sum;
  logic             prev_wrap;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      check("in_ready_rule", 64'(b12.in_ready), 64'(!b12.out_valid || b12.out_ready));
      if (stalled) begin
        check("stall_valid", 64'(b12.out_valid), 64'd1);
        check("stall_sum",   64'(b12.Sum),       64'(prev_sum));
        check("stall_wrap",  64'(b12.Wrap),      64'(prev_wrap));
      end
      if (b12.out_valid && b12.out_ready) begin
        if (q12.size() == 0) begin
          check("unexpected_out12", 64'd1, 64'd0);
        end else begin
          e = q12.pop_front();
          check("sum12",  64'(b12.Sum),  64'(e.sum));
          check("wrap12", 64'(b12.Wrap), 64'(e.wrap));
          if (lat_chk) check("latency12", 64'(cyc), 64'(e.acc + 1));
          nout12++;
        end
      end
      stalled   = b12.out_valid && !b12.out_ready;
      prev_sum  = b12.Sum;
      prev_wrap = b12.Wrap;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) begin
        check("unexpected_out8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        check("sum8",   64'(b8.Sum),       64'(e.sum));
        check("wrap8",  64'(b8.Wrap),      64'(e.wrap));
        check("range8", 64'(b8.Sum < 251), 64'd1);
        nout8++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b23.out_valid && b23.out_ready) begin
      if (q23.size() == 0) begin
        check("unexpected_out23", 64'd1, 64'd0);
      end else begin
        e = q23.pop_front();
        check("sum23",   64'(b23.Sum),           64'(e.sum));
        check("wrap23",  64'(b23.Wrap),          64'(e.wrap));
        check("range23", 64'(b23.Sum < 8380417), 64'd1);
        nout23++;
      end
    end
  end

  initial begin
    int   c8[3];
    int   c23[3];
    int   a;
    int   b;
    bit   s;
    exp_t e;

    ncmp    = 0;
    nfail   = 0;
    nout12  = 0;
    nout8   = 0;
    nout23  = 0;
    lat_chk = 1'b0;
    bp_en   = 1'b0;
    rst     = 1'b1;

    b12.in_valid  = 1'b1;
    b12.A         = 12'd7;
    b12.B         = 12'd3;
    b12.Sub       = 1'b0;
    b12.out_ready = 1'b1;
    b8.in_valid   = 1'b0;
    b8.A          = '0;
    b8.B          = '0;
    b8.Sub        = 1'b0;
    b8.out_ready  = 1'b1;
    b23.in_valid  = 1'b0;
    b23.A         = '0;
    b23.B         = '0;
    b23.Sub       = 1'b0;
    b23.out_ready = 1'b1;

    // Reset held two cycles with in_valid asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(b12.out_valid), 64'd0);
    check("rst_sum",       64'(b12.Sum),       64'd0);
    check("rst_wrap",      64'(b12.Wrap),      64'd0);
    check("rst_in_ready",  64'(b12.in_ready),  64'd1);
    rst          = 1'b0;
    b12.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(b12.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Boundary vectors for Q = 3329, with hand-computed results.
    lat_chk = 1'b1;
    send12(3000, 1000, 1'b0,  671, 1'b1, 1'b1);
    send12(3328,    0, 1'b0, 3328, 1'b0, 1'b1);
    send12(3328,    1, 1'b0,    0, 1'b1, 1'b1);
    send12(   5,   10, 1'b1, 3324, 1'b1, 1'b1);
    send12(  10,   10, 1'b1,    0, 1'b0, 1'b1);
    send12(   0, 3328, 1'b1,    1, 1'b1, 1'b1);

    // Back-to-back random stream, full throughput.
    for (int i = 0; i < 100; i++) begin
      a = int'($urandom_range(0, 3328));
      b = int'($urandom_range(0, 3328));
      s = 1'($urandom_range(0, 1));
      e = model(a, b, s, 3329);
      send12(a, b, s, int'(e.sum), e.wrap, 1'b1);
    end
    drain();
    lat_chk = 1'b0;

    // Random backpressure with continuous input.
    bp_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(0, 3328));
      b = int'($urandom_range(0, 3328));
      s = 1'($urandom_range(0, 1));
      e = model(a, b, s, 3329);
      send12(a, b, s, int'(e.sum), e.wrap, 1'b1);
    end
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    b12.out_ready = 1'b1;
    drain();
    check("count12", 64'(nout12), 64'd306);

    // Two transactions in flight behind a stall, then reset: neither may appear.
    b12.out_ready = 1'b0;
    send12(100, 200, 1'b0, 300, 1'b0, 1'b0);
    send12(300, 400, 1'b1, 3229, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    b12.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flush_out_valid", 64'(b12.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    check("flush_count12", 64'(nout12), 64'd306);

    // Corner sweep on the other two parameter sets.
    c8[0]  = 0;
    c8[1]  = 1;
    c8[2]  = 250;
    c23[0] = 0;
    c23[1] = 1;
    c23[2] = 8380416;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 2; k++) begin
          send8(c8[i], c8[j], k[0]);
          send23(c23[i], c23[j], k[0]);
        end
    drain();
    check("count8",  64'(nout8),  64'd18);
    check("count23", 64'(nout23), 64'd18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mod_add_sub.md
# mod_add_sub

Parametrised, pipelined modular adder/subtractor computing (A + B) mod Q or (A − B) mod Q on WIDTH-bit operands. It is the next generation of the single-bit full adder: a multi-bit, registered, valid/ready-handshaked arithmetic stage. It sits in the NTT datapath next to the butterfly multiplier and performs the add/sub half of each Cooley-Tukey/Gentleman-Sande butterfly.

## Interface
- WIDTH, 12, operand and result width in bits
- Q, 3329, modulus; constraint 2 ≤ Q ≤ 2^WIDTH − 1
- clk  input  1  rising-edge clock, sole clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  A/B/Sub valid this cycle
- in_ready  output  1  block accepts input this cycle
- A  input  WIDTH  operand, must satisfy A < Q
- B  input  WIDTH  operand, must satisfy B < Q
- Sub  input  1  0 = A + B, 1 = A − B
- out_valid  output  1  Sum/Wrap valid
- out_ready  input  1  downstream accepts output
- Sum  output  WIDTH  result, always in [0, Q−1] for legal inputs
- Wrap  output  1  1 when the modular correction was applied (sum ≥ Q, or difference < 0)

## Operation
- Two-stage pipeline, single global advance enable: adv = !out_valid | out_ready.
- in_ready = adv (combinational). Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage 1 (registered on adv): v1 <= in_valid; Sub1 <= Sub; raw1 (WIDTH+1 bits) <= A + B when Sub=0, else A − B in two's complement on WIDTH+1 bits (MSB = borrow).
- Stage 2 (registered on adv): out_valid <= v1.
  - Add: if raw1 ≥ Q then Sum <= raw1 − Q, Wrap <= 1; else Sum <= raw1[WIDTH−1:0], Wrap <= 0.
  - Sub: if raw1 MSB = 1 then Sum <= raw1 + Q (low WIDTH bits), Wrap <= 1; else Sum <= raw1[WIDTH−1:0], Wrap <= 0.
- All comparisons on WIDTH+1 bits; no intermediate truncation before correction.
- Bubbles are not collapsed: a stage with v=0 still occupies its slot; during a stall (adv=0) every register holds.
- When v1 = 0 at advance, out_valid <= 0 and Sum/Wrap hold their previous value (no requirement on data when out_valid = 0).
- Out-of-range operands (A ≥ Q or B ≥ Q): a single correction is still applied; Sum is not guaranteed < Q. Not a checked condition.

## Timing
- Reset (rst=1 at clock edge): v1, Sub1, raw1, out_valid, Sum, Wrap all cleared to 0. in_ready = 1 in the cycle after reset.
- Reset mid-operation flushes both stages; in-flight results are discarded, never presented.
- rst has priority over adv.
- Latency: 2 cycles; input accepted at edge n appears with out_valid=1 after edge n+1 (visible in cycle n+2), assuming no stall.
- Throughput: 1 result/cycle while out_ready = 1.
- Stall: out_valid=1 & out_ready=0 → in_ready=0 same cycle; Sum, Wrap, out_valid, and stage 1 stable until out_ready rises.
- Simultaneous output consume and input accept in one cycle is allowed (adv=1 via out_ready).
- out_valid, Sum, Wrap are registered outputs; in_ready is the only combinational output (depends on out_valid, out_ready).

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, Sum=0, Wrap=0, in_ready=1; assert rst while 2 results in flight → neither appears.
- Add boundary (Q=3329): A=3000,B=1000,Sub=0 → Sum=671, Wrap=1, 2 cycles later; A=3328,B=0 → 3328, Wrap=0; A=3328,B=1 → 0, Wrap=1.
- Sub boundary: A=5,B=10,Sub=1 → Sum=3324, Wrap=1; A=10,B=10 → 0, Wrap=0; A=0,B=3328 → 1, Wrap=1.
- Back-to-back stream of 100 random legal (A,B,Sub) with out_ready=1 → one result per cycle, in order, each matching a reference (A±B) mod Q.
- Backpressure: random out_ready (50%) with continuous in_valid → in_ready = !out_valid | out_ready every cycle, outputs stable while stalled, no loss/duplication across 200 transactions.
- Parameter sweep: WIDTH=8,Q=251 and WIDTH=23,Q=8380417 → exhaustive-corner checks (0, 1, Q−1 pairs, both ops) all in range and correct.
